// File: rtl/clk_div_switch.sv
// rtl/clk_div_switch.sv - glitch-free clock divider with handshaked ratio switching
// Ratio changes take effect only at a falling edge of clk_out.
module clk_div_switch #(
   parameter int NUM_RATIOS = 4,
   parameter int CNT_W      = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_RATIOS*CNT_W-1:0] div_cfg,
   input  logic [NUM_RATIOS-1:0]       sel,
   input  logic                        sel_valid,
   output logic                        sel_ready,
   output logic                        sel_err,
   output logic                        switch_done,
   output logic [NUM_RATIOS-1:0]       active_sel,
   output logic                        clk_out,
   output logic                        clk_en
);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_PEND} state_t;

   localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_RATIOS-1:0] SEL_ONE = {{(NUM_RATIOS-1){1'b0}}, 1'b1};

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      r_cur_h;
   logic [CNT_W-1:0]      r_pend_h;
   logic [NUM_RATIOS-1:0] r_pend_sel;
   logic [NUM_RATIOS-1:0] r_active_sel;
   logic                  r_clk_out;
   logic                  r_clk_en;
   logic                  r_sel_ready;
   logic                  r_sel_err;
   logic                  r_switch_done;

   logic [CNT_W-1:0]      w_req_h;
   logic [CNT_W-1:0]      w_h0;
   logic                  w_onehot;
   logic                  w_cfg_ok;
   logic                  w_accept;
   logic                  w_last;

   // sel is only trusted when one-hot, so OR-ing the selected slices is a mux
   always_comb begin
      w_req_h = '0;
      for (int k = 0; k < NUM_RATIOS; k++) begin
         if (sel[k]) begin
            w_req_h = w_req_h | div_cfg[k*CNT_W +: CNT_W];
         end
      end
   end

   assign w_h0     = div_cfg[CNT_W-1:0];
   assign w_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
   assign w_cfg_ok = w_onehot && (w_req_h != '0);
   assign w_accept = sel_valid && r_sel_ready;
   assign w_last   = (r_cnt == (r_cur_h - CNT_ONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_INIT;
         r_cnt         <= '0;
         r_cur_h       <= '0;
         r_pend_h      <= '0;
         r_pend_sel    <= SEL_ONE;
         r_active_sel  <= SEL_ONE;
         r_clk_out     <= 1'b0;
         r_clk_en      <= 1'b0;
         r_sel_ready   <= 1'b0;
         r_sel_err     <= 1'b0;
         r_switch_done <= 1'b0;
      end else begin
         r_clk_en      <= 1'b0;
         r_sel_err     <= 1'b0;
         r_switch_done <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (w_h0 != '0) begin
                  r_cur_h     <= w_h0;
                  r_cnt       <= '0;
                  r_state     <= S_RUN;
                  r_sel_ready <= 1'b1;
               end
            end
            S_RUN, S_PEND: begin
               if (w_last) begin
                  r_cnt     <= '0;
                  r_clk_out <= ~r_clk_out;
                  r_clk_en  <= ~r_clk_out;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
               if (r_state == S_RUN && w_accept) begin
                  if (w_cfg_ok) begin
                     r_pend_sel  <= sel;
                     r_pend_h    <= w_req_h;
                     r_state     <= S_PEND;
                     r_sel_ready <= 1'b0;
                  end else begin
                     r_sel_err <= 1'b1;
                  end
               end
               // new ratio starts with the low phase that this falling edge opens
               if (r_state == S_PEND && w_last && r_clk_out) begin
                  r_cur_h       <= r_pend_h;
                  r_active_sel  <= r_pend_sel;
                  r_switch_done <= 1'b1;
                  r_state       <= S_RUN;
                  r_sel_ready   <= 1'b1;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign sel_ready   = r_sel_ready;
   assign sel_err     = r_sel_err;
   assign switch_done = r_switch_done;
   assign active_sel  = r_active_sel;
   assign clk_out     = r_clk_out;
   assign clk_en      = r_clk_en;

endmodule

// File: doc/clk_div_switch.md
# clk_div_switch

Parametrised, glitch-free clock divider and ratio switcher for the phy_wifi clock tree. It derives one divided clock from a single source clock and selects among `NUM_RATIOS` programmable divide slots. Ratio changes are requested through a valid/ready handshake and are applied only at a falling edge of the output. No high or low phase of `clk_out` is ever shorter than a full phase of either the old or the new ratio. Downstream logic uses it to run baseband sections at software-selected rates without the per-clock synchronisers that multi-source muxing needs.

## Interface
- `NUM_RATIOS`, 4, number of divide slots (≥2).
- `CNT_W`, 8, width of each half-period value and of the internal counter.
- `clk` input 1: source clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `div_cfg` input `NUM_RATIOS*CNT_W`: slot k half-period `H_k` in bits `[k*CNT_W +: CNT_W]`, counted in `clk` cycles. `H=0` means the slot is disabled.
- `sel` input `NUM_RATIOS`: requested slot, one-hot.
- `sel_valid` input 1: switch request.
- `sel_ready` output 1: high when a request can be accepted.
- `sel_err` output 1: one-cycle pulse when a request is rejected.
- `switch_done` output 1: one-cycle pulse when a new ratio takes effect.
- `active_sel` output `NUM_RATIOS`: one-hot slot currently driving `clk_out`.
- `clk_out` output 1: divided clock, registered.
- `clk_en` output 1: one-cycle pulse, high in the cycle in which `clk_out` becomes 1.

## Operation
- States are INIT, RUN and PEND.
- **Reset values:** state INIT, `clk_out=0`, `clk_en=0`, `sel_ready=0`, `sel_err=0`, `switch_done=0`, `active_sel=1` (slot 0), counter 0, `cur_h=0`.
- **INIT:**
  - If `H_0≠0`: latch `cur_h=H_0`, set counter to 0, go to RUN.
  - If `H_0=0`: stay in INIT with `clk_out` held low.
- **RUN:**
  - The counter increments each cycle.
  - When `counter==cur_h-1`: toggle `clk_out` and clear the counter.
  - Output period is `2*cur_h` cycles at 50% duty.
  - `sel_ready=1` in RUN only.
- **Request acceptance:** a request is accepted on `sel_valid & sel_ready`.
  - Rejected if `sel` is not exactly one-hot, or if the requested slot has `H=0`. A rejection pulses `sel_err` the next cycle and the state stays RUN.
  - Otherwise latch `pend_sel` and `pend_h` from `div_cfg` at acceptance, then go to PEND.
  - Re-selecting the active slot is legal. It reloads `H` and is the only way a changed `div_cfg` for the active slot takes effect.
- **PEND:**
  - Division continues unchanged at `cur_h`.
  - On the cycle in which `clk_out` toggles 1→0:
    - load `cur_h=pend_h` and `active_sel=pend_sel`;
    - clear the counter;
    - pulse `switch_done`;
    - return to RUN.
  - The low phase that begins there already uses the new `H`.
  - `sel_valid` is ignored while in PEND.
- `div_cfg` is sampled only in INIT and at request acceptance. Changes at other times do not affect `clk_out`.
- Counter and compare arithmetic are `CNT_W` bits unsigned. `H=2^CNT_W-1` is the maximum and must work without wrap errors.

## Timing
- `clk_out` and `clk_en` are both registers. `clk_en` asserts in the same cycle `clk_out` first reads 1.
- With a constant `H`, edges of `clk_out` are exactly `H` cycles apart.
- **Start-up:** with `H_0=h`, the first `clk_out` rise follows the (1+h)-th `clk` rising edge after `rst_n` deasserts (INIT takes 1 cycle).
- **Switch latency:** worst case is one full old period (`2*cur_h` cycles) from acceptance to `switch_done`.
  - If `clk_out` is high when the request is accepted, the switch happens at the current high phase's end.
  - If `clk_out` is low, the switch waits through the remaining low phase and one full high phase.
- **`H=1`:** `clk_out` toggles every cycle (divide-by-2). Switching to or from `H=1` obeys the same falling-edge rule.
- **Reset mid-operation:** asserting `rst_n` low forces all reset values immediately, including `clk_out=0`. A pending request is discarded. Truncated phases are permitted only at reset.
- `sel_err` and `switch_done` never assert in the same cycle.

## Test plan
1. **Start-up:** `H_0=2`, release reset → first `clk_out` rise after the 3rd clk edge, period 4, `clk_en` pulse every 4 cycles, `active_sel=4'b0001`.
2. **Switch request while `clk_out` is high:** `H_0=3`, request slot 2 with `H_2=5` → `sel_ready` drops, old high phase completes at 3 cycles, `switch_done` pulses on that falling edge, then low 5 / high 5, `active_sel=4'b0100`.
3. **Glitch check:** random switching between `H` values {1, 2, 7, 255} → every `clk_out` phase length is ≥ min(old H, new H) and equals the governing `H`. The bench checks each edge interval.
4. **Rejections:**
   - `sel=4'b0110` → `sel_err` pulses, `clk_out` period unchanged, `active_sel` unchanged.
   - Request to slot 3 with `H_3=0` → same response.
5. **Busy and no-effect cases:**
   - Assert `sel_valid` during PEND → ignored, first request completes.
   - Change `H` of the active slot mid-run → no period change until that slot is re-selected.
6. **Reset in PEND:** assert `rst_n` low while in PEND → `clk_out=0` immediately, `active_sel=4'b0001`. After release with `H_0=0`, the block stays in INIT with `clk_out` low.
